// File: rtl/paddle_renderer.sv
// Paddle renderer: tracks the visible beam from the timing strobes, moves the paddle once per
// frame from two buttons with hold-to-accelerate, and emits the registered paddle pixel.
module paddle_renderer #(
   parameter int p_SCREEN_W     = 640,
   parameter int p_SCREEN_H     = 480,
   parameter int p_PADDLE_X     = 16,
   parameter int p_PADDLE_W     = 8,
   parameter int p_PADDLE_H     = 64,
   parameter int p_SLOW_STEP    = 2,
   parameter int p_FAST_STEP    = 6,
   parameter int p_ACCEL_FRAMES = 20
) (
   input  logic       i_Clk,
   input  logic       i_Rst_n,
   input  logic       i_HBlank,
   input  logic       i_VBlank,
   input  logic       i_HReset,
   input  logic       i_VReset,
   input  logic       i_Up,
   input  logic       i_Down,
   output logic       o_Video,
   output logic [8:0] o_PaddleY
);

   localparam int c_Y_MAX  = p_SCREEN_H - p_PADDLE_H;
   localparam int c_Y_RST  = c_Y_MAX / 2;
   localparam int c_HOLD_W = $clog2(p_ACCEL_FRAMES);

   localparam logic signed [10:0] c_Y_MAX_S   = 11'(c_Y_MAX);
   localparam logic signed [10:0] c_X_LO_S    = 11'(p_PADDLE_X);
   localparam logic signed [10:0] c_X_HI_S    = 11'(p_PADDLE_X + p_PADDLE_W);
   localparam logic signed [10:0] c_SCR_W_S   = 11'(p_SCREEN_W);
   localparam logic signed [10:0] c_PAD_H_S   = 11'(p_PADDLE_H);
   localparam logic signed [10:0] c_SLOW_S    = 11'(p_SLOW_STEP);
   localparam logic signed [10:0] c_FAST_S    = 11'(p_FAST_STEP);
   localparam logic [c_HOLD_W-1:0] c_HOLD_LAST = c_HOLD_W'(p_ACCEL_FRAMES - 1);

   typedef enum logic [1:0] {IDLE = 2'd0, SLOW = 2'd1, FAST = 2'd2} state_t;
   typedef enum logic [1:0] {DIR_NONE = 2'd0, DIR_UP = 2'd1, DIR_DOWN = 2'd2} dir_t;

   logic                up_m, up_s, dn_m, dn_s;
   logic [9:0]          col;
   logic [8:0]          row;
   logic                vb_prev;
   logic                tick;
   dir_t                dir, dir_last, dir_last_nxt;
   state_t              state, state_nxt;
   logic [c_HOLD_W-1:0] hold, hold_nxt, hold_inc;
   logic [8:0]          y_nxt;
   logic signed [10:0]  col_x, row_x, y_x;
   logic                pixel_on_p0;

   // Keeps the paddle inside the playfield; clamping is purely positional.
   function automatic logic [8:0] clamp_y(input logic signed [10:0] v);
      logic signed [10:0] r;
      r = v;
      if (r < 11'sd0)
         r = 11'sd0;
      else if (r > c_Y_MAX_S)
         r = c_Y_MAX_S;
      return r[8:0];
   endfunction

   function automatic logic [8:0] move_y(input logic [8:0] y, input logic signed [10:0] step,
                                         input dir_t d);
      logic signed [10:0] y_s;
      y_s = signed'({2'b00, y});
      if (d == DIR_UP)
         return clamp_y(y_s - step);
      else if (d == DIR_DOWN)
         return clamp_y(y_s + step);
      else
         return y;
   endfunction

   always_ff @(posedge i_Clk or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         up_m <= 1'b0;
         up_s <= 1'b0;
         dn_m <= 1'b0;
         dn_s <= 1'b0;
      end else begin
         up_m <= i_Up;
         up_s <= up_m;
         dn_m <= i_Down;
         dn_s <= dn_m;
      end
   end

   // Beam counters saturate instead of wrapping so a missing strobe cannot alias the paddle.
   always_ff @(posedge i_Clk or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         col <= '0;
         row <= '0;
      end else begin
         if (i_HReset)
            col <= '0;
         else if (!i_HBlank && col != 10'h3FF)
            col <= col + 10'd1;
         if (i_VReset)
            row <= '0;
         else if (i_HReset && !i_VBlank && row != 9'h1FF)
            row <= row + 9'd1;
      end
   end

   // Stage p0: pixel hit test on the current counters.
   always_comb begin
      col_x       = signed'({1'b0, col});
      row_x       = signed'({2'b00, row});
      y_x         = signed'({2'b00, o_PaddleY});
      pixel_on_p0 = !i_HBlank && !i_VBlank
                    && col_x >= c_X_LO_S && col_x < c_X_HI_S && col_x < c_SCR_W_S
                    && row_x >= y_x && row_x < (y_x + c_PAD_H_S);
   end

   assign tick = i_VBlank & ~vb_prev;

   always_comb begin
      dir = DIR_NONE;
      if (up_s && !dn_s)
         dir = DIR_UP;
      else if (dn_s && !up_s)
         dir = DIR_DOWN;
   end

   always_comb begin
      state_nxt    = state;
      hold_nxt     = hold;
      dir_last_nxt = dir_last;
      y_nxt        = o_PaddleY;
      hold_inc     = hold + 1'b1;
      if (tick) begin
         dir_last_nxt = dir;
         unique case (state)
            IDLE: begin
               if (dir != DIR_NONE) begin
                  state_nxt = SLOW;
                  hold_nxt  = '0;
                  y_nxt     = move_y(o_PaddleY, c_SLOW_S, dir);
               end
            end
            SLOW: begin
               if (dir == DIR_NONE || dir != dir_last) begin
                  state_nxt = IDLE;
               end else begin
                  y_nxt    = move_y(o_PaddleY, c_SLOW_S, dir);
                  hold_nxt = hold_inc;
                  if (hold_inc == c_HOLD_LAST)
                     state_nxt = FAST;
               end
            end
            FAST: begin
               if (dir == DIR_NONE || dir != dir_last)
                  state_nxt = IDLE;
               else
                  y_nxt = move_y(o_PaddleY, c_FAST_S, dir);
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   // Stage p1: registered pixel and once-per-frame position/FSM update.
   always_ff @(posedge i_Clk or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         o_Video   <= 1'b0;
         o_PaddleY <= 9'(c_Y_RST);
         vb_prev   <= 1'b0;
         state     <= IDLE;
         hold      <= '0;
         dir_last  <= DIR_NONE;
      end else begin
         o_Video   <= pixel_on_p0;
         o_PaddleY <= y_nxt;
         vb_prev   <= i_VBlank;
         state     <= state_nxt;
         hold      <= hold_nxt;
         dir_last  <= dir_last_nxt;
      end
   end

endmodule

// File: tb/tb_paddle_renderer.sv
// Directed bench for paddle_renderer using a miniature raster (24 visible columns, 300 lines).
module tb_paddle_renderer;

   localparam int VIS_W    = 24;
   localparam int LINE_LEN = 28;
   localparam int NL       = 300;

   logic       i_Clk = 1'b0;
   logic       i_Rst_n;
   logic       i_HBlank, i_VBlank, i_HReset, i_VReset, i_Up, i_Down;
   logic       o_Video;
   logic [8:0] o_PaddleY;

   int n_tests = 0;
   int n_fail  = 0;

   paddle_renderer dut (
      .i_Clk     (i_Clk),
      .i_Rst_n   (i_Rst_n),
      .i_HBlank  (i_HBlank),
      .i_VBlank  (i_VBlank),
      .i_HReset  (i_HReset),
      .i_VReset  (i_VReset),
      .i_Up      (i_Up),
      .i_Down    (i_Down),
      .o_Video   (o_Video),
      .o_PaddleY (o_PaddleY)
   );

   always #5 i_Clk = ~i_Clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step(input logic hb, input logic vb, input logic hr, input logic vr);
      i_HBlank = hb;
      i_VBlank = vb;
      i_HReset = hr;
      i_VReset = vr;
      @(posedge i_Clk);
      #1;
   endtask

   task automatic reset_pulse();
      i_Rst_n = 1'b0;
      step(1'b1, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0, 1'b0);
      i_Rst_n = 1'b1;
   endtask

   task automatic short_frame();
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, i == 2, 1'b0);
      for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b1);
   endtask

   task automatic render_frame(input int exp_y, input string tag);
      int   high, bad;
      logic exp_v;
      high = 0;
      bad  = 0;
      for (int ln = 0; ln < NL; ln++) begin
         for (int p = 0; p < LINE_LEN; p++) begin
            step(p >= VIS_W, 1'b0, p == LINE_LEN - 1, 1'b0);
            exp_v = (p < VIS_W) && p >= 16 && p < 24 && ln >= exp_y && ln < exp_y + 64;
            if (o_Video === 1'b1) high++;
            if (o_Video !== exp_v) bad++;
         end
      end
      for (int ln = 0; ln < 2; ln++) begin
         for (int p = 0; p < LINE_LEN; p++) begin
            step(p >= VIS_W, 1'b1, p == LINE_LEN - 1, ln == 1);
            if (o_Video !== 1'b0) bad++;
         end
      end
      check({tag, "_bad_pixels"}, bad, 0);
      check({tag, "_high_count"}, high, 512);
      check({tag, "_y"}, o_PaddleY, exp_y);
   endtask

   initial begin
      i_Rst_n  = 1'b0;
      i_HBlank = 1'b1;
      i_VBlank = 1'b0;
      i_HReset = 1'b0;
      i_VReset = 1'b0;
      i_Up     = 1'b0;
      i_Down   = 1'b0;
      #12;
      check("rst_video", o_Video, 0);
      check("rst_y", o_PaddleY, 208);
      check("rst_state", dut.state, 0);
      @(posedge i_Clk);
      #1;
      i_Rst_n = 1'b1;

      // Idle rendering, two frames.
      render_frame(208, "frame1");
      render_frame(208, "frame2");
      check("idle_state", dut.state, 0);

      // Up held three frames.
      i_Up = 1'b1;
      short_frame(); check("up1_y", o_PaddleY, 206);
      short_frame(); check("up2_y", o_PaddleY, 204);
      short_frame(); check("up3_y", o_PaddleY, 202);
      check("up_state", dut.state, 1);
      i_Up = 1'b0;
      short_frame(); check("up_rel_y", o_PaddleY, 202);
      check("up_rel_state", dut.state, 0);

      // Down held into FAST and into the bottom clamp.
      reset_pulse();
      check("rst2_y", o_PaddleY, 208);
      i_Down = 1'b1;
      for (int k = 1; k <= 50; k++) begin
         short_frame();
         if (k == 1)  check("dn1_y", o_PaddleY, 210);
         if (k == 19) begin check("dn19_y", o_PaddleY, 246); check("dn19_state", dut.state, 1); end
         if (k == 20) begin check("dn20_y", o_PaddleY, 248); check("dn20_state", dut.state, 2); end
         if (k == 21) check("dn21_y", o_PaddleY, 254);
         if (k == 47) check("dn47_y", o_PaddleY, 410);
         if (k == 48) check("dn48_y", o_PaddleY, 416);
         if (k == 50) begin check("dn50_y", o_PaddleY, 416); check("dn50_state", dut.state, 2); end
      end
      i_Down = 1'b0;
      short_frame();

      // Both buttons held: no movement.
      i_Up   = 1'b1;
      i_Down = 1'b1;
      for (int k = 0; k < 5; k++) short_frame();
      check("both_y", o_PaddleY, 416);
      check("both_state", dut.state, 0);
      i_Up   = 1'b0;
      i_Down = 1'b0;

      // Up into FAST, then reverse.
      reset_pulse();
      i_Up = 1'b1;
      for (int k = 0; k < 20; k++) short_frame();
      check("upf20_y", o_PaddleY, 168);
      check("upf20_state", dut.state, 2);
      short_frame();
      check("upf21_y", o_PaddleY, 162);
      i_Up   = 1'b0;
      i_Down = 1'b1;
      short_frame();
      check("rev_y", o_PaddleY, 162);
      check("rev_state", dut.state, 0);
      short_frame();
      check("rev2_y", o_PaddleY, 164);
      check("rev2_state", dut.state, 1);
      i_Down = 1'b0;

      // Mid-line reset while the paddle pixel is lit (paddle rows 164..227).
      for (int ln = 0; ln < 210; ln++)
         for (int p = 0; p < LINE_LEN; p++) step(p >= VIS_W, 1'b0, p == LINE_LEN - 1, 1'b0);
      for (int p = 0; p < 18; p++) step(1'b0, 1'b0, 1'b0, 1'b0);
      check("mid_video_on", o_Video, 1);
      i_Rst_n = 1'b0;
      #1;
      check("mid_rst_video", o_Video, 0);
      check("mid_rst_y", o_PaddleY, 208);
      @(posedge i_Clk);
      #1;
      i_Rst_n = 1'b1;
      for (int p = 19; p < LINE_LEN; p++) step(p >= VIS_W, 1'b0, p == LINE_LEN - 1, 1'b0);
      for (int ln = 0; ln < 2; ln++)
         for (int p = 0; p < LINE_LEN; p++) step(p >= VIS_W, 1'b1, p == LINE_LEN - 1, ln == 1);
      render_frame(208, "post_rst");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
